cn_msg_expand: RTL and testbench

//  Check-node message expander for the min-sum decoder. It takes one compressed check-node record:
//   - minima (LSB first) and their edge indices, as produced by the min-finder;
//   - per-edge input signs.
//  It serially emits one signed check-to-variable message per edge, DEG beats per record.
//  It sits between the check-node min stage and the variable-node update / message RAM write port.

---
 rtl/cn_msg_expand_pkg.sv | 12 +
 rtl/cn_edge_mag.sv | 30 +++
 rtl/cn_msg_expand.sv | 101 ++++++++++
 tb/tb_cn_msg_expand.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cn_msg_expand_pkg.sv
// Shared defaults and types for the check-node message expander.
package cn_pkg;
  localparam int ABS_WID_DEF = 6;
  localparam int IDX_WID_DEF = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic                   sign;
    logic [ABS_WID_DEF-1:0] mag;
  } msg_t;
endpackage

// File: rtl/cn_edge_mag.sv
// Per-edge magnitude: first minimum not owned by this edge, offset-reduced and clamped at 0.
module cn_edge_mag #(
  parameter int ABS_WID = 6,
  parameter int MIN_NUM = 3,
  parameter int IDX_WID = 3,
  parameter int OFFSET  = 0
) (
  input  logic [ABS_WID*MIN_NUM-1:0] min_i,
  input  logic [IDX_WID*MIN_NUM-1:0] idx_i,
  input  logic [IDX_WID-1:0]         edge_i,
  output logic [ABS_WID-1:0]         mag_o
);
  localparam logic [ABS_WID-1:0] OFF = ABS_WID'(OFFSET);

  logic [ABS_WID-1:0] sel;
  logic               found;

  always_comb begin
    // All-duplicate indices fall back to the last entry.
    sel   = min_i[ABS_WID*(MIN_NUM-1) +: ABS_WID];
    found = 1'b0;
    for (int k = 0; k < MIN_NUM; k++) begin
      if (!found && idx_i[IDX_WID*k +: IDX_WID] != edge_i) begin
        sel   = min_i[ABS_WID*k +: ABS_WID];
        found = 1'b1;
      end
    end
    mag_o = (int'(sel) > OFFSET) ? sel - OFF : '0;
  end
endmodule

// File: rtl/cn_msg_expand.sv
// Expands one compressed check-node record into DEG serial signed check-to-variable messages.
module cn_msg_expand import cn_pkg::*; #(
  parameter int ABS_WID = ABS_WID_DEF,
  parameter int MIN_NUM = 3,
  parameter int IDX_WID = IDX_WID_DEF,
  parameter int DEG     = 4,
  parameter int OFFSET  = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [ABS_WID*MIN_NUM-1:0] i_min,
  input  logic [IDX_WID*MIN_NUM-1:0] i_idx,
  input  logic [DEG-1:0]             i_sign,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ABS_WID:0]           o_msg,
  output logic [IDX_WID-1:0]         o_edge,
  output logic                       o_last
);
  state_t                     state_q, state_d;
  logic [IDX_WID-1:0]         cnt_q, cnt_d;
  logic [ABS_WID*MIN_NUM-1:0] min_q, min_d;
  logic [IDX_WID*MIN_NUM-1:0] idx_q, idx_d;
  logic [DEG-1:0]             sign_q, sign_d;
  logic                       prod_q, prod_d;
  logic [ABS_WID:0]           msg_q, msg_d;
  logic                       last_q, last_d;
  logic [ABS_WID-1:0]         mag_d;
  logic                       sgn_d;
  logic                       accept, adv;

  assign o_valid = (state_q == BUSY);
  assign o_last  = last_q & o_valid;
  assign o_ready = !i_rst && (state_q == IDLE || (o_last && i_ready));
  assign o_msg   = msg_q;
  assign o_edge  = cnt_q;
  assign accept  = i_valid & o_ready;
  assign adv     = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = '0;
      min_d   = i_min;
      idx_d   = i_idx;
      sign_d  = i_sign;
      prod_d  = ^i_sign;
    end else if (adv) begin
      if (last_q) state_d = IDLE;
      else        cnt_d   = cnt_q + 1'b1;
    end
  end

  // Message is computed from next-state values so it registers alongside the counter.
  cn_edge_mag #(
    .ABS_WID(ABS_WID), .MIN_NUM(MIN_NUM), .IDX_WID(IDX_WID), .OFFSET(OFFSET)
  ) u_mag (
    .min_i (min_d),
    .idx_i (idx_d),
    .edge_i(cnt_d),
    .mag_o (mag_d)
  );

  always_comb begin
    sgn_d = prod_d;
    for (int e = 0; e < DEG; e++)
      if (cnt_d == IDX_WID'(e)) sgn_d = prod_d ^ sign_d[e];
    msg_d  = {sgn_d, mag_d};
    last_d = (cnt_d == IDX_WID'(DEG-1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
      sign_q  <= '0;
      prod_q  <= 1'b0;
      msg_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
      msg_q   <= msg_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_cn_msg_expand.sv
// Directed bench for cn_msg_expand: one OFFSET=0 and one OFFSET=3 instance on shared inputs.
module tb_cn_msg_expand;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_ready;
  logic [17:0] i_min;
  logic [8:0]  i_idx;
  logic [3:0]  i_sign;
  logic        o_ready, o_valid, o_last;
  logic [6:0]  o_msg;
  logic [2:0]  o_edge;
  logic        off_ready, off_valid, off_last;
  logic [6:0]  off_msg;
  logic [2:0]  off_edge;
  int          nvec = 0;
  int          nerr = 0;

  always #5 i_clk = ~i_clk;

  cn_msg_expand #(.OFFSET(0)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_min(i_min), .i_idx(i_idx), .i_sign(i_sign), .o_valid(o_valid),
    .i_ready(i_ready), .o_msg(o_msg), .o_edge(o_edge), .o_last(o_last)
  );

  cn_msg_expand #(.OFFSET(3)) u_off (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(off_ready),
    .i_min(i_min), .i_idx(i_idx), .i_sign(i_sign), .o_valid(off_valid),
    .i_ready(i_ready), .o_msg(off_msg), .o_edge(off_edge), .o_last(off_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int e, input int mag, input bit sg, input bit off);
    logic [6:0] exp_msg;
    exp_msg = {sg, 6'(mag)};
    chk("beat_valid", off ? off_valid : o_valid, 1);
    chk("beat_edge",  off ? off_edge  : o_edge,  e);
    chk("beat_msg",   off ? off_msg   : o_msg,   exp_msg);
    chk("beat_last",  off ? off_last  : o_last,  (e == 3));
    chk("beat_ready", off ? off_ready : o_ready, (e == 3) && i_ready);
  endtask

  task automatic load(input logic [17:0] mn, input logic [8:0] ix, input logic [3:0] sg);
    i_min = mn; i_idx = ix; i_sign = sg; i_valid = 1'b1;
  endtask

  // Entered mid-cycle; sends one record with i_ready=1 and checks all four beats.
  task automatic run_rec(input logic [17:0] mn, input logic [8:0] ix, input logic [3:0] sg,
                         input int m0, input int m1, input int m2, input int m3,
                         input logic [3:0] es, input bit off);
    int em[4];
    em = '{m0, m1, m2, m3};
    load(mn, ix, sg);
    i_ready = 1'b1;
    #1;
    chk("idle_ready", o_ready, 1);
    chk("idle_valid", o_valid, 0);
    @(posedge i_clk); #1 i_valid = 1'b0; #1;
    for (int e = 0; e < 4; e++) begin
      beat(e, em[e], es[e], off);
      @(posedge i_clk); #2;
    end
    chk("done_valid", o_valid, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_min = '0; i_idx = '0; i_sign = '0;
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_msg",   o_msg,   0);
    chk("rst_edge",  o_edge,  0);
    chk("rst_last",  o_last,  0);
    i_rst = 1'b0; #1;
    chk("post_rst_ready", o_ready, 1);

    // Basic: min LSB-first 2,5,9 with indices 0,1,3
    run_rec({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0000, 5, 2, 2, 2, 4'b0000, 1'b0);
    // Signs: product 0 and product 1
    run_rec({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0110, 5, 2, 2, 2, 4'b0110, 1'b0);
    run_rec({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0111, 5, 2, 2, 2, 4'b1000, 1'b0);
    // Index beyond DEG never matches; all-duplicate index falls back to last entry
    run_rec({6'd9, 6'd5, 6'd2}, {3'd7, 3'd6, 3'd5}, 4'b0000, 2, 2, 2, 2, 4'b0000, 1'b0);
    run_rec({6'd9, 6'd5, 6'd2}, {3'd0, 3'd0, 3'd0}, 4'b0000, 9, 2, 2, 2, 4'b0000, 1'b0);
    // Offset=3 instance: clamped and non-clamped cases
    run_rec({6'd4, 6'd3, 6'd1}, {3'd2, 3'd1, 3'd0}, 4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
    run_rec({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0001, 2, 0, 0, 0, 4'b1110, 1'b1);

    // Backpressure on edge 1 for 3 cycles
    load({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0000);
    @(posedge i_clk); #1 i_valid = 1'b0; #1;
    beat(0, 5, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    i_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", o_valid, 1);
      chk("bp_edge",  o_edge,  1);
      chk("bp_msg",   o_msg,   7'd2);
      chk("bp_ready", o_ready, 0);
      @(posedge i_clk); #2;
    end
    i_ready = 1'b1; #1;
    beat(1, 2, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    beat(2, 2, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    beat(3, 2, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    chk("bp_done_valid", o_valid, 0);

    // Back-to-back: second record accepted in the first record's last beat
    load({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0000);
    @(posedge i_clk); #1;
    load({6'd9, 6'd5, 6'd2}, {3'd7, 3'd6, 3'd5}, 4'b0111);
    #1;
    for (int e = 0; e < 4; e++) begin
      beat(e, (e == 0) ? 5 : 2, 1'b0, 1'b0);
      chk("b2b_ready_a", o_ready, (e == 3));
      @(posedge i_clk); #1;
      if (e == 3) i_valid = 1'b0;
      #1;
    end
    for (int e = 0; e < 4; e++) begin
      beat(e, 2, (e == 3), 1'b0);
      @(posedge i_clk); #2;
    end
    chk("b2b_done_valid", o_valid, 0);

    // Reset during edge 2
    load({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0000);
    @(posedge i_clk); #1 i_valid = 1'b0; #1;
    beat(0, 5, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    beat(1, 2, 1'b0, 1'b0);
    @(posedge i_clk); #2;
    beat(2, 2, 1'b0, 1'b0);
    i_rst = 1'b1; #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_edge",  o_edge,  0);
    @(posedge i_clk); #2;
    i_rst = 1'b0; #1;
    chk("rel_ready", o_ready, 1);
    chk("rel_valid", o_valid, 0);
    run_rec({6'd9, 6'd5, 6'd2}, {3'd3, 3'd1, 3'd0}, 4'b0110, 5, 2, 2, 2, 4'b0110, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
